tt_um_yavar_count_checker: RTL and testbench
============================================

Name: tt_um_yavar_count_checker

Overview:
Receive-side companion to the team's 4b counter tile. Samples a free-running binary count on ui_in, locks onto it after a run of consecutive +1 steps, then flags every skipped, repeated or corrupted step. Lock state and flags go to uo_out; a saturating error count goes to the bidirectional pins, all driven as outputs.

Parameters:
WIDTH, 4, observed count width; legal 1..4, taken from ui_in[WIDTH-1:0].
LOCK_COUNT, 4, consecutive valid +1 steps (including the first sample) needed to lock; legal 2..15.
LOSS_COUNT, 3, consecutive mismatches while locked that drop lock; legal 1..15.
ERR_W, 8, error counter width; legal 1..8.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
ena  input  1  design enable; when low, samples are treated as not valid
ui_in  input  8  [3:0] observed count, [4] sample valid, [5] clear error count, [7:6] unused
uo_out  output  8  [0] locked, [1] err_pulse, [2] syncing, [3] err_sat, [7:4] last accepted sample (zero-extended)
uio_in  input  8  unused
uio_out  output  8  error count, zero-extended to 8b
uio_oe  output  8  constant 8'hFF

Behaviour:
- Reset: one clock, clk; asynchronous active-low reset, rst_n. While rst_n is low, every register clears immediately: state=HUNT, all uo_out=0, uio_out=0. uio_oe is always 8'hFF.
- Input stage: ui_in[5:0] and ena are registered once (sample_r, valid_r = ui_in[4] & ena, clr_r). All outputs are registered. Pin-to-output latency is 2 clk edges.
- expected = last_r + 1, mod 2^WIDTH. Wrap from 2^WIDTH-1 to 0 counts as a match.
- last_r takes sample_r on every valid_r cycle, in all states.
- FSM, evaluated only when valid_r=1; with valid_r=0, state and counters hold.
  - HUNT: go to SYNC, good_cnt=1.
  - SYNC: if match, good_cnt++; when the new value equals LOCK_COUNT, go to LOCKED and clear bad_cnt. If mismatch, good_cnt=1 and stay in SYNC (restart from this sample). No errors are counted in SYNC.
  - LOCKED, match: bad_cnt=0.
  - LOCKED, mismatch: err_pulse=1 for exactly one cycle, err_cnt increments, bad_cnt++. When bad_cnt reaches LOSS_COUNT, go to HUNT with good_cnt=0 and bad_cnt=0.
  - A mismatch resyncs to the observed value, so a single skip yields exactly one error.
- Outputs: locked = (state==LOCKED). syncing = (state==SYNC). err_pulse is registered and high only in the cycle after the offending sample is evaluated.
- err_cnt saturates at 2^ERR_W-1. err_sat = (err_cnt == max).
- clr_r=1 sets err_cnt to 0 on the next edge. If clear and an increment happen together, clear wins (result 0). Clear does not affect the FSM or err_pulse.
- Lock loss does not clear err_cnt.
- ui_in[7:6] and uio_in are ignored.

Optional Feature:
YAVAR_CHK_SYNC2_EN:
- Defined: adds a second register stage on ui_in[5:0] for metastability protection when the counter comes from another clock domain. Pin-to-output latency becomes 3 edges. Behaviour is otherwise identical, and the extra stage also clears on rst_n.
- Undefined: single input stage, 2-edge latency.

Test Plan:
(Defaults assumed unless stated.)
1. Reset, then ui_in[4]=1 with counts 5,6,7,8 on consecutive cycles -> syncing=1 two edges after 5; locked=1 two edges after 8; err_cnt=0.
2. Locked; feed 13,14,15,0,1 -> no err_pulse, uio_out=0, uo_out[7:4]=1 at the end (wrap accepted).
3. Locked; feed 3,4,6,7,8 -> single one-cycle err_pulse two edges after 6; uio_out=1; locked stays 1. Drop valid for 3 cycles mid-stream -> state and outputs hold.
4. Locked; feed 3,9,2,12 -> three err_pulses, uio_out=+3, locked falls to 0 after the third error. Then feed 0,1,2,3 -> relock.
5. Preload err_cnt=255 by forcing mismatches; another mismatch -> stays 255 with err_sat=1. Assert ui_in[5] in the same cycle as a mismatch -> uio_out=0 and err_pulse still fires.
6. rst_n low mid-SYNC, asynchronously between edges -> uo_out and uio_out go to 0 without waiting for clk. After release, the first valid sample enters SYNC.

Source files
------------

// File: rtl/tt_um_yavar_count_checker.sv
// Count checker: locks onto a free-running +1 count on ui_in and flags skipped/repeated steps.
// Optional macro YAVAR_CHK_SYNC2_EN adds a second input register stage (3-edge latency).
module tt_um_yavar_count_checker #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 3,
  parameter int unsigned ERR_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_e;

  localparam logic [3:0]       LOCK_C  = 4'(LOCK_COUNT);
  localparam logic [3:0]       LOSS_C  = 4'(LOSS_COUNT);
  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic [5:0]       pin_in;
  logic             ena_in;
  logic [WIDTH-1:0] sample_q;
  logic             valid_q;
  logic             clr_q;

`ifdef YAVAR_CHK_SYNC2_EN
  logic [5:0] pin_s1_q;
  logic       ena_s1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pin_s1_q <= '0;
      ena_s1_q <= 1'b0;
    end else begin
      pin_s1_q <= ui_in[5:0];
      ena_s1_q <= ena;
    end
  end

  assign pin_in = pin_s1_q;
  assign ena_in = ena_s1_q;
`else
  assign pin_in = ui_in[5:0];
  assign ena_in = ena;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= '0;
      valid_q  <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      sample_q <= pin_in[WIDTH-1:0];
      valid_q  <= pin_in[4] & ena_in;
      clr_q    <= pin_in[5];
    end
  end

  state_e           state_q;
  logic [WIDTH-1:0] last_q;
  logic [3:0]       good_q;
  logic [3:0]       bad_q;
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] err_d;
  logic             err_pulse_q;
  logic             locked_q;
  logic             syncing_q;
  logic             err_sat_q;
  logic             match;
  logic             err_inc;

  assign match   = (sample_q == last_q + ONE_W);
  assign err_inc = valid_q && (state_q == LOCKED) && !match;

  // Clear has priority over a simultaneous increment.
  always_comb begin
    err_d = err_q;
    if (clr_q) begin
      err_d = '0;
    end else if (err_inc && (err_q != ERR_MAX)) begin
      err_d = err_q + ERR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      last_q      <= '0;
      good_q      <= '0;
      bad_q       <= '0;
      err_q       <= '0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
      syncing_q   <= 1'b0;
      err_sat_q   <= 1'b0;
    end else begin
      err_pulse_q <= 1'b0;
      err_q       <= err_d;
      err_sat_q   <= (err_d == ERR_MAX);
      if (valid_q) begin
        last_q <= sample_q;
        unique case (state_q)
          HUNT: begin
            state_q   <= SYNC;
            good_q    <= 4'd1;
            syncing_q <= 1'b1;
            locked_q  <= 1'b0;
          end
          SYNC: begin
            if (match) begin
              good_q <= good_q + 4'd1;
              if (good_q + 4'd1 == LOCK_C) begin
                state_q   <= LOCKED;
                bad_q     <= '0;
                syncing_q <= 1'b0;
                locked_q  <= 1'b1;
              end
            end else begin
              good_q <= 4'd1;
            end
          end
          LOCKED: begin
            if (match) begin
              bad_q <= '0;
            end else begin
              err_pulse_q <= 1'b1;
              if (bad_q + 4'd1 == LOSS_C) begin
                state_q  <= HUNT;
                good_q   <= '0;
                bad_q    <= '0;
                locked_q <= 1'b0;
              end else begin
                bad_q <= bad_q + 4'd1;
              end
            end
          end
          default: begin
            state_q   <= HUNT;
            locked_q  <= 1'b0;
            syncing_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign uo_out  = {4'(last_q), err_sat_q, syncing_q, err_pulse_q, locked_q};
  assign uio_out = 8'(err_q);
  assign uio_oe  = 8'hFF;

  logic unused_ok;
  assign unused_ok = ^{ui_in, uio_in};

endmodule

// File: tb/tb_tt_um_yavar_count_checker.sv
// Bench for tt_um_yavar_count_checker: directed test-plan steps then random stream vs a behavioural model.
module tb_tt_um_yavar_count_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int total = 0;
  int bad   = 0;

  tt_um_yavar_count_checker dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  // Model: input captured one edge, judged on the next.
  bit       p_valid, p_clr;
  int       p_val;
  bit       m_locked, m_sync, m_pulse;
  int       m_last, m_run, m_miss, m_errs;

  function automatic void model_reset();
    p_valid = 0; p_clr = 0; p_val = 0;
    m_locked = 0; m_sync = 0; m_pulse = 0;
    m_last = 0; m_run = 0; m_miss = 0; m_errs = 0;
  endfunction

  function automatic void model_edge(input logic [7:0] ui, input logic en);
    bit good;
    bit inc;
    inc = 0;
    m_pulse = 0;
    if (p_valid) begin
      good = (((m_last + 1) % 16) == p_val);
      if (!m_locked && !m_sync) begin
        m_sync = 1; m_run = 1;
      end else if (m_sync) begin
        if (good) begin
          m_run++;
          if (m_run == 4) begin m_sync = 0; m_locked = 1; m_miss = 0; end
        end else m_run = 1;
      end else begin
        if (good) m_miss = 0;
        else begin
          m_pulse = 1; inc = 1; m_miss++;
          if (m_miss == 3) begin m_locked = 0; m_miss = 0; m_run = 0; end
        end
      end
      m_last = p_val;
    end
    if (p_clr) m_errs = 0;
    else if (inc && m_errs < 255) m_errs++;
    p_valid = ui[4] & en;
    p_clr   = ui[5];
    p_val   = int'(ui[3:0]);
  endfunction

  function automatic logic [7:0] exp_uo();
    logic [3:0] l;
    l = 4'(m_last);
    return {l, (m_errs == 255), m_sync, m_pulse, m_locked};
  endfunction

  task automatic compare(input string tag);
    logic [7:0] e_uo, e_err;
    e_uo  = exp_uo();
    e_err = 8'(m_errs);
    total++;
    assert (uo_out === e_uo) else begin
      bad++; $error("FAIL %s uo_out got %h exp %h", tag, uo_out, e_uo);
    end
    total++;
    assert (uio_out === e_err) else begin
      bad++; $error("FAIL %s uio_out got %h exp %h", tag, uio_out, e_err);
    end
    total++;
    assert (uio_oe === 8'hFF) else begin
      bad++; $error("FAIL %s uio_oe got %h exp ff", tag, uio_oe);
    end
  endtask

  task automatic step(input logic [7:0] ui, input logic en, input string tag);
    ui_in = ui; ena = en;
    @(posedge clk);
    model_edge(ui, en);
    #1;
    compare(tag);
  endtask

  task automatic cnt(input int v, input string tag);
    step({4'b0001, 4'(v)}, 1'b1, tag);
  endtask

  task automatic idle(input string tag);
    step(8'h00, 1'b1, tag);
  endtask

  task automatic expect_bit(input logic obs, input logic exp, input string tag);
    total++;
    assert (obs === exp) else begin
      bad++; $error("FAIL %s got %b exp %b", tag, obs, exp);
    end
  endtask

  task automatic expect_byte(input logic [7:0] obs, input logic [7:0] exp, input string tag);
    total++;
    assert (obs === exp) else begin
      bad++; $error("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  initial begin
    int v;
    logic [7:0] r;
    rst_n = 1'b0; ena = 1'b0; ui_in = '0; uio_in = '0;
    model_reset();
    #12;
    compare("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: acquire lock
    cnt(5, "t1_5"); cnt(6, "t1_6"); cnt(7, "t1_7"); cnt(8, "t1_8");
    idle("t1_flush");
    expect_bit(uo_out[0], 1'b1, "t1_locked");
    expect_byte(uio_out, 8'h00, "t1_err0");

    // 2: wrap is a match
    for (int i = 9; i <= 17; i++) cnt(i % 16, "t2_wrap");
    idle("t2_flush");
    expect_byte(uio_out, 8'h00, "t2_err0");
    expect_byte({4'd0, uo_out[7:4]}, 8'h01, "t2_last");

    // 3: single skip -> one error, valid gaps hold
    cnt(2, "t3"); cnt(3, "t3"); cnt(4, "t3"); cnt(6, "t3_skip");
    step(8'h07, 1'b1, "t3_novalid"); step(8'h17, 1'b0, "t3_noena"); step(8'h00, 1'b1, "t3_novalid");
    cnt(7, "t3"); cnt(8, "t3");
    idle("t3_flush");
    expect_byte(uio_out, 8'h01, "t3_err1");
    expect_bit(uo_out[0], 1'b1, "t3_locked");

    // 4: three errors drop lock, then relock
    for (int i = 9; i <= 18; i++) cnt(i % 16, "t4_pre");
    cnt(3, "t4"); cnt(9, "t4"); cnt(2, "t4"); cnt(12, "t4");
    idle("t4_flush");
    expect_bit(uo_out[0], 1'b0, "t4_unlocked");
    expect_bit(uo_out[1], 1'b1, "t4_pulse");
    expect_byte(uio_out, 8'h04, "t4_err4");
    cnt(0, "t4_re"); cnt(1, "t4_re"); cnt(2, "t4_re"); cnt(3, "t4_re");
    idle("t4_reflush");
    expect_bit(uo_out[0], 1'b1, "t4_relocked");

    // 5: saturate, then clear together with a mismatch
    for (int k = 0; k < 90; k++) begin
      cnt(0, "t5"); cnt(1, "t5"); cnt(2, "t5"); cnt(3, "t5");
      cnt(9, "t5"); cnt(2, "t5"); cnt(12, "t5");
    end
    cnt(0, "t5"); cnt(1, "t5"); cnt(2, "t5"); cnt(3, "t5"); cnt(3, "t5_rep");
    idle("t5_flush");
    expect_byte(uio_out, 8'hFF, "t5_sat");
    expect_bit(uo_out[3], 1'b1, "t5_satflag");
    step(8'h3A, 1'b1, "t5_clr");
    idle("t5_clrflush");
    expect_byte(uio_out, 8'h00, "t5_cleared");
    expect_bit(uo_out[1], 1'b1, "t5_clrpulse");

    // 6: async reset mid-SYNC
    cnt(4, "t6"); cnt(5, "t6"); cnt(6, "t6");
    expect_bit(uo_out[2], 1'b1, "t6_syncing");
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    expect_byte(uo_out, 8'h00, "t6_async_uo");
    expect_byte(uio_out, 8'h00, "t6_async_err");
    @(posedge clk); #2;
    rst_n = 1'b1;
    cnt(9, "t6_after"); idle("t6_after");
    expect_bit(uo_out[2], 1'b1, "t6_resync");

    // random stream
    v = 0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 9) != 0) v = (v + 1) % 16;
      else v = $urandom_range(0, 15);
      r = 8'($urandom);
      r[3:0] = 4'(v);
      r[4] = ($urandom_range(0, 19) != 0);
      r[5] = ($urandom_range(0, 39) == 0);
      uio_in = 8'($urandom);
      step(r, ($urandom_range(0, 19) != 0), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
